// File: rtl/sc_mseq_pkg.sv
// Shared encodings for the ARC micro-sequencer: branch conditions, sequencer
// states and the helper that sizes the microword.
package sc_mseq_pkg;

    localparam logic [2:0] COND_NEXT   = 3'd0;
    localparam logic [2:0] COND_N      = 3'd1;
    localparam logic [2:0] COND_Z      = 3'd2;
    localparam logic [2:0] COND_V      = 3'd3;
    localparam logic [2:0] COND_C      = 3'd4;
    localparam logic [2:0] COND_IR13   = 3'd5;
    localparam logic [2:0] COND_JUMP   = 3'd6;
    localparam logic [2:0] COND_DECODE = 3'd7;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int DECODE_WIDTH = 11;

    function automatic int mir_width(int aw, int rf, int af, int cf);
        return 3 * rf + af + cf + aw + 5;
    endfunction

endpackage

// File: rtl/sc_micro_sequencer_cbl.sv
// Control branch logic: picks the next control-store address from the current
// microword's COND field, the PSR flags and the instruction register.
module sc_mseq_cbl
    import sc_mseq_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic [2:0]            cond_i,
    input  logic [3:0]            flags_i,
    input  logic [31:0]           ir_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic [ADDR_WIDTH-1:0] cur_addr_i,
    input  logic [0:0]            state_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] decode_addr;
    logic                  unused_ir;

    assign incr_addr = cur_addr_i + ADDR_WIDTH'(1);

    // Decode address: 1, op, op3, 00 -- zero-extended above bit 10.
    assign decode_addr = ADDR_WIDTH'({1'b1, ir_i[31:30], ir_i[24:19], 2'b00});

    assign unused_ir = ^{ir_i[29:25], ir_i[18:14], ir_i[12:0]};

    always_comb begin
        next_addr_o = incr_addr;
        case (cond_i)
            COND_NEXT:   next_addr_o = incr_addr;
            COND_N:      next_addr_o = flags_i[3] ? jump_addr_i : incr_addr;
            COND_Z:      next_addr_o = flags_i[2] ? jump_addr_i : incr_addr;
            COND_V:      next_addr_o = flags_i[1] ? jump_addr_i : incr_addr;
            COND_C:      next_addr_o = flags_i[0] ? jump_addr_i : incr_addr;
            COND_IR13:   next_addr_o = ir_i[13]   ? jump_addr_i : incr_addr;
            COND_JUMP:   next_addr_o = jump_addr_i;
            COND_DECODE: next_addr_o = decode_addr;
            default:     next_addr_o = incr_addr;
        endcase
        if (state_i == ST_BOOT) begin
            next_addr_o = '0;
        end
    end

endmodule

// File: rtl/sc_micro_sequencer.sv
// Microinstruction register and sequencer for the ARC control section: holds
// the current microword, slices it into control fields and steps the address.
module sc_micro_sequencer
    import sc_mseq_pkg::*;
#(
    parameter int ADDR_WIDTH    = 11,
    parameter int REG_FIELD     = 6,
    parameter int ALU_FIELD     = 4,
    parameter int COND_FIELD    = 3,
    parameter int MIR_DATAWIDTH = mir_width(ADDR_WIDTH, REG_FIELD, ALU_FIELD, COND_FIELD)
) (
    input  logic                     SC_MSEQ_CLOCK_50,
    input  logic                     SC_MSEQ_RESET_InLow,
    input  logic                     SC_MSEQ_clear_InLow,
    input  logic                     SC_MSEQ_stall_InHigh,
    input  logic [MIR_DATAWIDTH-1:0] SC_MSEQ_data_InBUS,
    input  logic [31:0]              SC_MSEQ_IR_InBUS,
    input  logic [3:0]               SC_MSEQ_Flags_InBUS,
    output logic [ADDR_WIDTH-1:0]    SC_MSEQ_NextAddr_OutBUS,
    output logic [ADDR_WIDTH-1:0]    SC_MSEQ_CurAddr_OutBUS,
    output logic                     SC_MSEQ_Valid_Out,
    output logic [REG_FIELD-1:0]     SC_MSEQ_A_OutBUS,
    output logic [REG_FIELD-1:0]     SC_MSEQ_B_OutBUS,
    output logic [REG_FIELD-1:0]     SC_MSEQ_C_OutBUS,
    output logic                     SC_MSEQ_AMUX_Out,
    output logic                     SC_MSEQ_BMUX_Out,
    output logic                     SC_MSEQ_CMUX_Out,
    output logic                     SC_MSEQ_Read_Out,
    output logic                     SC_MSEQ_Write_Out,
    output logic [ALU_FIELD-1:0]     SC_MSEQ_ALU_OutBUS,
    output logic [COND_FIELD-1:0]    SC_MSEQ_Cond_OutBUS,
    output logic [ADDR_WIDTH-1:0]    SC_MSEQ_JumpAddr_OutBUS
);

    // Field offsets, LSB upwards: JUMPADDR, COND, ALU, WR, RD, CMUX, C, BMUX, B, AMUX, A.
    localparam int OFF_JUMP = 0;
    localparam int OFF_COND = OFF_JUMP + ADDR_WIDTH;
    localparam int OFF_ALU  = OFF_COND + COND_FIELD;
    localparam int OFF_WR   = OFF_ALU + ALU_FIELD;
    localparam int OFF_RD   = OFF_WR + 1;
    localparam int OFF_CMUX = OFF_RD + 1;
    localparam int OFF_C    = OFF_CMUX + 1;
    localparam int OFF_BMUX = OFF_C + REG_FIELD;
    localparam int OFF_B    = OFF_BMUX + 1;
    localparam int OFF_AMUX = OFF_B + REG_FIELD;
    localparam int OFF_A    = OFF_AMUX + 1;

    logic [0:0]               state_q, state_d;
    logic [MIR_DATAWIDTH-1:0] mir_q, mir_d;
    logic [ADDR_WIDTH-1:0]    cur_q, cur_d;
    logic [ADDR_WIDTH-1:0]    next_addr;

    sc_mseq_cbl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cbl (
        .cond_i      (mir_q[OFF_COND +: 3]),
        .flags_i     (SC_MSEQ_Flags_InBUS),
        .ir_i        (SC_MSEQ_IR_InBUS),
        .jump_addr_i (mir_q[OFF_JUMP +: ADDR_WIDTH]),
        .cur_addr_i  (cur_q),
        .state_i     (state_q),
        .next_addr_o (next_addr)
    );

    // Flush wins over stall; the BOOT fetch always lands at address 0.
    always_comb begin
        state_d = state_q;
        mir_d   = mir_q;
        cur_d   = cur_q;
        if (!SC_MSEQ_clear_InLow) begin
            state_d = ST_BOOT;
            mir_d   = '0;
            cur_d   = '0;
        end else if (!SC_MSEQ_stall_InHigh) begin
            state_d = ST_RUN;
            mir_d   = SC_MSEQ_data_InBUS;
            cur_d   = (state_q == ST_RUN) ? next_addr : '0;
        end
    end

    always_ff @(posedge SC_MSEQ_CLOCK_50 or negedge SC_MSEQ_RESET_InLow) begin
        if (!SC_MSEQ_RESET_InLow) begin
            state_q <= ST_BOOT;
            mir_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            mir_q   <= mir_d;
            cur_q   <= cur_d;
        end
    end

    assign SC_MSEQ_NextAddr_OutBUS = next_addr;
    assign SC_MSEQ_CurAddr_OutBUS  = cur_q;
    assign SC_MSEQ_Valid_Out       = (state_q == ST_RUN);
    assign SC_MSEQ_A_OutBUS        = mir_q[OFF_A +: REG_FIELD];
    assign SC_MSEQ_AMUX_Out        = mir_q[OFF_AMUX];
    assign SC_MSEQ_B_OutBUS        = mir_q[OFF_B +: REG_FIELD];
    assign SC_MSEQ_BMUX_Out        = mir_q[OFF_BMUX];
    assign SC_MSEQ_C_OutBUS        = mir_q[OFF_C +: REG_FIELD];
    assign SC_MSEQ_CMUX_Out        = mir_q[OFF_CMUX];
    assign SC_MSEQ_Read_Out        = mir_q[OFF_RD];
    assign SC_MSEQ_Write_Out       = mir_q[OFF_WR];
    assign SC_MSEQ_ALU_OutBUS      = mir_q[OFF_ALU +: ALU_FIELD];
    assign SC_MSEQ_Cond_OutBUS     = mir_q[OFF_COND +: COND_FIELD];
    assign SC_MSEQ_JumpAddr_OutBUS = mir_q[OFF_JUMP +: ADDR_WIDTH];

endmodule
